// File: rtl/hilo_muldiv_seq.sv
// HI/LO register pair with a multi-cycle MULT/MULTU/DIV/DIVU sequencer and MTHI/MTLO writes.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational one.
module hilo_muldiv_seq #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] DIV0_Q = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              hilo_rd,
  input  logic              cancel,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              stall
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

  state_t              state_q;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                is_div_q, div0_q, neg_res_q, neg_rem_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                done_q;

  logic                is_signed, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     add_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] mul_res;
  logic [DATA_W-1:0]   quo_res, rem_res;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_prod;
`endif

  // Operands are reduced to magnitudes up front; signs are reapplied in SIGN.
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & src_a[DATA_W-1];
    b_neg     = is_signed & src_b[DATA_W-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
`endif
  end

  // acc_q = {partial product, multiplier} for mul, {remainder, dividend/quotient} for div.
  always_comb begin
    add_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      if (div_diff[DATA_W])
        acc_d = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
      else
        acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    end else begin
      acc_d = {add_sum, acc_q[DATA_W-1:1]};
    end
    mul_res = neg_res_q ? -acc_q : acc_q;
    quo_res = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem_res = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !cancel) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                is_div_q  <= op[1];
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                div0_q    <= op[1] && (src_b == '0);
                cnt_q     <= '0;
                if (op[1]) begin
                  // A zero divisor keeps the raw dividend so HI returns it untouched.
                  acc_q   <= {{DATA_W{1'b0}}, (src_b == '0) ? src_a : a_mag};
                  opnd_q  <= b_mag;
                  state_q <= RUN;
                end else begin
`ifdef MULDIV_FAST_MUL_EN
                  acc_q   <= fast_prod;
                  opnd_q  <= a_mag;
                  state_q <= SIGN;
`else
                  acc_q   <= {{DATA_W{1'b0}}, b_mag};
                  opnd_q  <= a_mag;
                  state_q <= RUN;
`endif
                end
              end
              3'd4:    hi_q <= src_a;
              3'd5:    lo_q <= src_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cancel) begin
            state_q <= IDLE;
          end else if (div0_q) begin
            state_q <= SIGN;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) state_q <= SIGN;
          end
        end
        SIGN: begin
          state_q <= IDLE;
          if (!cancel) begin
            done_q <= 1'b1;
            if (div0_q) begin
              lo_q <= DIV0_Q;
              hi_q <= acc_q[DATA_W-1:0];
            end else if (is_div_q) begin
              lo_q <= quo_res;
              hi_q <= rem_res;
            end else begin
              {hi_q, lo_q} <= mul_res;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);
  assign stall = busy & (start | hilo_rd);
endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed vector table plus hand sequences for stall, cancel and asynchronous reset.
module tb_hilo_muldiv_seq;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hilo_rd = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int DIV0_LAT = 2;

  hilo_muldiv_seq #(.DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hilo_rd(hilo_rd), .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Presents one op for one cycle; returns at the negedge after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, bcnt;
    logic seen;

    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
    vecs[2]  = '{3'd0, 32'd6,        32'd7,        32'h0,        32'd42,       MUL_LAT};
    vecs[3]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        MUL_LAT};
    vecs[4]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h1,        32'h0,        MUL_LAT};
    vecs[5]  = '{3'd3, 32'd100,      32'd7,        32'h2,        32'hE,        DIV_LAT};
    vecs[6]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
    vecs[7]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, DIV_LAT};
    vecs[8]  = '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h3,        DIV_LAT};
    vecs[9]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, DIV_LAT};
    vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF, DIV_LAT};
    vecs[11] = '{3'd3, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, DIV0_LAT};
    vecs[12] = '{3'd2, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, DIV0_LAT};

    repeat (2) @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_stall", stall, 0);
    resetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(cyc, bcnt);
      $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d", i, vecs[i].op,
               vecs[i].a, vecs[i].b, hi, lo, cyc);
      chk($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].lat);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    issue(3'd4, 32'h11111111, 32'h0);
    $display("mthi a=11111111 -> hi=%h lo=%h busy=%b", hi, lo, busy);
    chk("mthi_hi", hi, 32'h11111111);
    chk("mthi_lo", lo, 32'hFFFFFFFF);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", done, 0);
    issue(3'd5, 32'h22222222, 32'h0);
    $display("mtlo a=22222222 -> hi=%h lo=%h", hi, lo);
    chk("mtlo_lo", lo, 32'h22222222);
    chk("mtlo_hi", hi, 32'h11111111);
    hilo_rd = 1'b1;
    #1 chk("idle_hilo_rd_stall", stall, 0);
    hilo_rd = 1'b0;

    // Stall: reads and a new MTHI during a divide are held off until it completes.
    issue(3'd3, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    hilo_rd = 1'b1;
    #1 chk("busy_hilo_rd_stall", stall, 1);
    hilo_rd = 1'b0;
    start = 1'b1; op = 3'd4; src_a = 32'h0000AAAA;
    #1 chk("busy_start_stall", stall, 1);
    chk("busy_hi_unchanged", hi, 32'h11111111);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!done) chk("stalled_hi_held", hi, 32'h11111111);
    end
    $display("stall seq: divu done hi=%h lo=%h stall=%b", hi, lo, stall);
    chk("stall_div_hi", hi, 32'h2);
    chk("stall_div_lo", lo, 32'hE);
    chk("stall_released", stall, 0);
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    $display("stall seq: mthi replay hi=%h lo=%h", hi, lo);
    chk("replay_mthi_hi", hi, 32'h0000AAAA);
    chk("replay_mthi_lo", lo, 32'hE);

    // Cancel while running.
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_run_busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    $display("cancel in RUN -> hi=%h lo=%h done_seen=%b", hi, lo, seen);
    chk("cancel_run_done", seen, 0);
    chk("cancel_run_hi", hi, 32'h0000AAAA);
    chk("cancel_run_lo", lo, 32'hE);

    // Cancel landing on the SIGN cycle of a divide-by-zero.
    issue(3'd3, 32'h00001234, 32'd0);
    @(negedge clk);
    chk("sign_busy", busy, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    $display("cancel in SIGN -> hi=%h lo=%h done=%b busy=%b", hi, lo, done, busy);
    chk("cancel_sign_busy", busy, 0);
    chk("cancel_sign_done", done, 0);
    chk("cancel_sign_hi", hi, 32'h0000AAAA);
    chk("cancel_sign_lo", lo, 32'hE);

    // Cancel beats start in IDLE.
    @(negedge clk);
    start = 1'b1; op = 3'd4; src_a = 32'h00005555; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'd7; cancel = 1'b0;
    $display("cancel+mthi in IDLE -> hi=%h busy=%b", hi, busy);
    chk("cancel_beats_start_hi", hi, 32'h0000AAAA);
    chk("cancel_beats_start_busy", busy, 0);

    // Asynchronous reset in the middle of a divide.
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    repeat (19) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    $display("async reset mid-op -> hi=%h lo=%h busy=%b", hi, lo, busy);
    chk("areset_hi", hi, 0);
    chk("areset_lo", lo, 0);
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    @(negedge clk);
    resetn = 1'b1;

    issue(3'd0, 32'd6, 32'd7);
    wait_done(cyc, bcnt);
    $display("post-reset mult 6*7 -> hi=%h lo=%h latency=%0d", hi, lo, cyc);
    chk("post_reset_mult_lat", cyc, MUL_LAT);
    chk("post_reset_mult_lo", lo, 32'd42);
    chk("post_reset_mult_hi", hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
